// File: rtl/mux_scan_n.sv
// Registered N-channel, W-bit multiplexer with two modes: manual channel select,
// or an automatic scan that dwells on each channel for a programmable number of cycles.
module mux_scan_n #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int SEL_W    = $clog2(CHANNELS),
    parameter int DWELL_W  = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel_in,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic [CHANNELS*WIDTH-1:0] din,
    output logic [WIDTH-1:0]          dout,
    output logic [SEL_W-1:0]          sel_out,
    output logic                      dout_valid,
    output logic                      ch_wrap
);

    typedef enum logic [1:0] {IDLE, MANUAL, SCAN} state_t;

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

    state_t               state_q, state_d;
    logic [SEL_W-1:0]     sel_q, sel_next;
    logic [DWELL_W-1:0]   dwell_cnt, cnt_next, cnt_cur, dwell_last;
    logic                 valid_next, wrap_next;

    // Mode is decided by the inputs at each edge, so en/mode changes take effect on that same edge.
    // Comparing with >= lets a shortened dwell advance immediately instead of waiting for the counter to wrap.
    always_comb begin
        state_d    = IDLE;
        sel_next   = sel_q;
        cnt_next   = dwell_cnt;
        valid_next = 1'b0;
        wrap_next  = 1'b0;
        dwell_last = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        cnt_cur    = (state_q == MANUAL) ? '0 : dwell_cnt;

        if (en) begin
            state_d = mode ? SCAN : MANUAL;
        end

        unique case (state_d)
            MANUAL: begin
                valid_next = 1'b1;
                cnt_next   = '0;
                sel_next   = (32'(sel_in) >= CHANNELS) ? LAST_CH : sel_in;
            end
            SCAN: begin
                valid_next = 1'b1;
                if (cnt_cur >= dwell_last) begin
                    cnt_next = '0;
                    if (sel_q == LAST_CH) begin
                        sel_next  = '0;
                        wrap_next = 1'b1;
                    end else begin
                        sel_next = sel_q + SEL_W'(1);
                    end
                end else begin
                    cnt_next = cnt_cur + DWELL_W'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            dwell_cnt  <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            ch_wrap    <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_next;
            dwell_cnt  <= cnt_next;
            dout_valid <= valid_next;
            ch_wrap    <= wrap_next;
            if (state_d != IDLE) begin
                dout <= din[int'(sel_next)*WIDTH +: WIDTH];
            end
        end
    end

    assign sel_out = sel_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: directed stimulus pushes hand-computed expectations,
// and a negedge monitor pops and compares them against a 4-channel and a 3-channel instance.
module tb_mux_scan_n;

    logic        clk = 1'b0;
    logic        rst_n, en, mode;
    logic [1:0]  sel_in;
    logic [15:0] dwell;
    logic [31:0] din;
    logic [23:0] din3;

    logic [7:0]  dout0, dout1;
    logic [1:0]  sel0, sel1;
    logic        valid0, valid1, wrap0, wrap1;

    assign din3 = din[23:0];

    mux_scan_n #(.WIDTH(8), .CHANNELS(4), .DWELL_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .dwell(dwell),
        .din(din), .dout(dout0), .sel_out(sel0), .dout_valid(valid0), .ch_wrap(wrap0)
    );

    mux_scan_n #(.WIDTH(8), .CHANNELS(3), .DWELL_W(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_in(sel_in), .dwell(dwell),
        .din(din3), .dout(dout1), .sel_out(sel1), .dout_valid(valid1), .ch_wrap(wrap1)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] due;
        logic        inst;
        logic [7:0]  dout;
        logic [1:0]  sel;
        logic        valid;
        logic        wrap;
    } exp_t;

    exp_t  sb[$];
    string names[$];
    int    cyc = 0;
    int    n_compared = 0;
    int    n_mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic applyStimulus(input logic r, input logic e, input logic m,
                                 input logic [1:0] s, input logic [15:0] dw);
        @(negedge clk);
        rst_n  = r;
        en     = e;
        mode   = m;
        sel_in = s;
        dwell  = dw;
    endtask

    task automatic expectOut(input int inst, input int d, input int s, input int v,
                             input int w, input string name);
        exp_t x;
        x.due   = 32'(cyc + 1);
        x.inst  = inst[0];
        x.dout  = d[7:0];
        x.sel   = s[1:0];
        x.valid = v[0];
        x.wrap  = w[0];
        sb.push_back(x);
        names.push_back(name);
    endtask

    task automatic cmpField(input string name, input string field, input int act, input int req);
        n_compared++;
        if (act != req) begin
            n_mismatched++;
            $display("[TB] FAIL %0s.%0s at cycle %0d: actual %0h required %0h", name, field, cyc, act, req);
        end
    endtask

    task automatic checkOutput(input exp_t x, input string name);
        if (x.inst == 1'b0) begin
            cmpField(name, "dout",  int'(dout0),  int'(x.dout));
            cmpField(name, "sel",   int'(sel0),   int'(x.sel));
            cmpField(name, "valid", int'(valid0), int'(x.valid));
            cmpField(name, "wrap",  int'(wrap0),  int'(x.wrap));
        end else begin
            cmpField(name, "dout",  int'(dout1),  int'(x.dout));
            cmpField(name, "sel",   int'(sel1),   int'(x.sel));
            cmpField(name, "valid", int'(valid1), int'(x.valid));
            cmpField(name, "wrap",  int'(wrap1),  int'(x.wrap));
        end
    endtask

    // Monitor: expectations become due one edge after the stimulus that produced them.
    exp_t  mon_x;
    string mon_n;
    always @(negedge clk) begin
        while (sb.size() > 0 && int'(sb[0].due) <= cyc) begin
            mon_x = sb.pop_front();
            mon_n = names.pop_front();
            checkOutput(mon_x, mon_n);
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: bench did not finish, actual running required done");
        $fatal(1, "[TB] timeout");
    end

    logic [7:0] chv [4];
    int scan_sel [13];
    int scan_wrap [13];
    int z_sel [5];
    int z_wrap [5];
    int clamp_sel [4];

    initial begin
        chv       = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        scan_sel  = '{0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0, 0};
        scan_wrap = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        z_sel     = '{0, 1, 2, 3, 0};
        z_wrap    = '{1, 0, 0, 0, 1};
        clamp_sel = '{0, 1, 2, 2};

        rst_n  = 1'b0;
        en     = 1'b1;
        mode   = 1'b1;
        sel_in = 2'd0;
        dwell  = 16'd3;
        din    = 32'hDDCCBBAA;

        repeat (3) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'd3);
            expectOut(0, 0, 0, 0, 0, "reset");
        end

        // Release edge is the first scan edge; the reset cycle showed channel 0 too.
        for (int k = 0; k < 13; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'd3);
            expectOut(0, int'(chv[scan_sel[k]]), scan_sel[k], 1, scan_wrap[k], "scan3");
        end

        for (int s = 0; s < 4; s++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2'(s), 16'd3);
            expectOut(0, int'(chv[s]), s, 1, 0, "manual");
            expectOut(1, int'(chv[clamp_sel[s]]), clamp_sel[s], 1, 0, "clamp");
        end

        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'd0);
            expectOut(0, int'(chv[z_sel[k]]), z_sel[k], 1, z_wrap[k], "dwell0");
        end

        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'd5);
            expectOut(0, 8'hAA, 0, 1, 0, "dwell5");
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'd2);
        expectOut(0, 8'hBB, 1, 1, 0, "shrink");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'd2);
        expectOut(0, 8'hBB, 1, 1, 0, "shrink");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'd2);
        expectOut(0, 8'hCC, 2, 1, 0, "shrink");

        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 16'd5);
        expectOut(0, 8'hAA, 0, 1, 0, "manual0");
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'd5);
            expectOut(0, 8'hAA, 0, 1, 0, "pre_hold");
        end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 16'd5);
            din = 32'hDDCCBB11;
            expectOut(0, 8'hAA, 0, 0, 0, "hold");
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'd5);
        din = 32'hDDCCBBAA;
        expectOut(0, 8'hAA, 0, 1, 0, "resume");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'd5);
        expectOut(0, 8'hAA, 0, 1, 0, "resume");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'd5);
        expectOut(0, 8'hBB, 1, 1, 0, "resume");
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd0, 16'd5);
        expectOut(0, 8'hBB, 1, 1, 0, "resume");

        applyStimulus(1'b0, 1'b1, 1'b1, 2'd0, 16'd5);
        expectOut(0, 0, 0, 0, 0, "midreset");
        expectOut(1, 0, 0, 0, 0, "midreset");

        repeat (3) @(negedge clk);
        cmpField("drain", "pending", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
